// File: rtl/key_pulse_gen_if.sv
// key_pulse_gen_if -- groups the key input and the pulse/status outputs of
// key_pulse_gen into one bundle.
//   key_raw   : raw, asynchronous, bouncing pushbutton level
//   pulse     : one-cycle press strobe (feeds the state-stepper's data_in)
//   key_level : debounced key level
//   state     : debouncer FSM state, for debug/LEDs
// Modports: master = the side that drives the key and watches the outputs,
//           slave  = key_pulse_gen itself.
interface key_pulse_gen_if;
   logic       key_raw;
   logic       pulse;
   logic       key_level;
   logic [1:0] state;

   modport master (
      output key_raw,
      input  pulse,
      input  key_level,
      input  state
   );

   modport slave (
      input  key_raw,
      output pulse,
      output key_level,
      output state
   );
endinterface

// File: rtl/key_pulse_gen.sv
// key_pulse_gen -- pushbutton debouncer that turns an accepted press into a
// single-cycle pulse.
//   clk        : system clock, all logic on its rising edge
//   reset      : synchronous, active-high reset
//   kif.key_raw   (in)  : raw bouncing key level, synchronized with 2 flops
//   kif.pulse     (out) : registered one-cycle strobe per accepted press
//   kif.key_level (out) : registered debounced level (HELD or DB_RELEASE)
//   kif.state     (out) : FSM state IDLE=00, DB_PRESS=01, HELD=10, DB_RELEASE=11
// Optional feature: define KEY_PULSE_AUTOREPEAT_EN to add auto-repeat pulses
// while the key stays HELD (REPEAT_DELAY after the press, then every
// REPEAT_PERIOD cycles). Without the macro the REPEAT_* parameters are only
// range-checked and no repeat logic exists.
module key_pulse_gen #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 10000000
) (
   input  logic            clk,
   input  logic            reset,
   key_pulse_gen_if.slave  kif
);

   localparam logic [1:0] IDLE       = 2'b00;
   localparam logic [1:0] DB_PRESS   = 2'b01;
   localparam logic [1:0] HELD       = 2'b10;
   localparam logic [1:0] DB_RELEASE = 2'b11;

   // A debounce window of 0 cycles is treated as 1 cycle.
   localparam int               DB_LAST_I = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES - 1 : 0;
   localparam logic [CNT_W-1:0] L_DB_LAST = CNT_W'(DB_LAST_I);

   // The terminal count must be representable so the counter never wraps.
   if ($clog2(DB_LAST_I + 1) > CNT_W) begin : g_bad_cnt_w
      $error("key_pulse_gen: CNT_W too narrow for DEBOUNCE_CYCLES");
   end
   if ((REPEAT_DELAY < 0) || (REPEAT_PERIOD < 0)) begin : g_bad_repeat
      $error("key_pulse_gen: REPEAT_DELAY/REPEAT_PERIOD must be non-negative");
   end

   logic             r_sync1;
   logic             r_key_s;
   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_pulse;
   logic             r_key_level;

   logic [1:0]       w_state_nx;
   logic [CNT_W-1:0] w_cnt_nx;
   logic             w_press_fire;
   logic             w_pulse_nx;

   always_comb begin
      w_state_nx   = r_state;
      w_cnt_nx     = r_cnt;
      w_press_fire = 1'b0;
      case (r_state)
         IDLE: begin
            if (r_key_s) begin
               w_state_nx = DB_PRESS;
               w_cnt_nx   = '0;
            end
         end
         DB_PRESS: begin
            if (!r_key_s) begin
               w_state_nx = IDLE;
            end else if (r_cnt == L_DB_LAST) begin
               w_state_nx   = HELD;
               w_press_fire = 1'b1;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         HELD: begin
            if (!r_key_s) begin
               w_state_nx = DB_RELEASE;
               w_cnt_nx   = '0;
            end
         end
         DB_RELEASE: begin
            if (r_key_s) begin
               w_state_nx = HELD;
            end else if (r_cnt == L_DB_LAST) begin
               w_state_nx = IDLE;
            end else begin
               w_cnt_nx = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

`ifdef KEY_PULSE_AUTOREPEAT_EN
   localparam int RD_LAST_I = (REPEAT_DELAY  > 1) ? REPEAT_DELAY  - 1 : 0;
   localparam int RP_LAST_I = (REPEAT_PERIOD > 1) ? REPEAT_PERIOD - 1 : 0;
   localparam int RMAX_I    = (RD_LAST_I > RP_LAST_I) ? RD_LAST_I : RP_LAST_I;
   // Widened beyond CNT_W when the repeat intervals need more bits.
   localparam int RCNT_W    = ($clog2(RMAX_I + 1) > CNT_W) ? $clog2(RMAX_I + 1) : CNT_W;
   localparam logic [RCNT_W-1:0] L_RD_LAST = RCNT_W'(RD_LAST_I);
   localparam logic [RCNT_W-1:0] L_RP_LAST = RCNT_W'(RP_LAST_I);

   logic [RCNT_W-1:0] r_rcnt;
   logic              r_rep_phase;   // 0: waiting for first repeat, 1: periodic
   logic [RCNT_W-1:0] w_rcnt_nx;
   logic              w_rep_phase_nx;
   logic              w_rep_fire;

   // Counts only while staying in HELD; DB_RELEASE leaves it frozen so a
   // release bounce resumes the same window.
   always_comb begin
      w_rcnt_nx      = r_rcnt;
      w_rep_phase_nx = r_rep_phase;
      w_rep_fire     = 1'b0;
      if ((r_state == DB_PRESS) && (w_state_nx == HELD)) begin
         w_rcnt_nx      = '0;
         w_rep_phase_nx = 1'b0;
      end else if ((r_state == HELD) && (w_state_nx == HELD)) begin
         if (r_rcnt == (r_rep_phase ? L_RP_LAST : L_RD_LAST)) begin
            w_rep_fire     = 1'b1;
            w_rcnt_nx      = '0;
            w_rep_phase_nx = 1'b1;
         end else begin
            w_rcnt_nx = r_rcnt + RCNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rcnt      <= '0;
         r_rep_phase <= 1'b0;
      end else begin
         r_rcnt      <= w_rcnt_nx;
         r_rep_phase <= w_rep_phase_nx;
      end
   end

   assign w_pulse_nx = w_press_fire | w_rep_fire;
`else
   assign w_pulse_nx = w_press_fire;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1     <= 1'b0;
         r_key_s     <= 1'b0;
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_pulse     <= 1'b0;
         r_key_level <= 1'b0;
      end else begin
         r_sync1     <= kif.key_raw;
         r_key_s     <= r_sync1;
         r_state     <= w_state_nx;
         r_cnt       <= w_cnt_nx;
         r_pulse     <= w_pulse_nx;
         // HELD and DB_RELEASE both have state[1] set.
         r_key_level <= w_state_nx[1];
      end
   end

   assign kif.pulse     = r_pulse;
   assign kif.key_level = r_key_level;
   assign kif.state     = r_state;

endmodule

// File: tb/tb_key_pulse_gen.sv
module tb_key_pulse_gen;

   logic clk;
   logic r_reset;
   logic r_key;

   int unsigned n_checks;
   int unsigned n_errors;

   key_pulse_gen_if kif  ();
   key_pulse_gen_if kif0 ();

   assign kif.key_raw  = r_key;
   assign kif0.key_raw = r_key;

   key_pulse_gen #(
      .DEBOUNCE_CYCLES (4),
      .CNT_W           (8),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) dut (
      .clk   (clk),
      .reset (r_reset),
      .kif   (kif)
   );

   // Zero debounce window must behave like a one-cycle window.
   key_pulse_gen #(
      .DEBOUNCE_CYCLES (0),
      .CNT_W           (8),
      .REPEAT_DELAY    (10),
      .REPEAT_PERIOD   (5)
   ) dut0 (
      .clk   (clk),
      .reset (r_reset),
      .kif   (kif0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       key;
      logic       pulse;
      logic       lvl;
      logic [1:0] st;
   } vec_t;

   vec_t vecs[$];

   function automatic void addv(input int unsigned n, input logic k, input logic p,
                                input logic l, input logic [1:0] s);
      vec_t v;
      v.key = k; v.pulse = p; v.lvl = l; v.st = s;
      for (int unsigned i = 0; i < n; i++) vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive the key, let one rising edge sample it, then look at outputs.
   task automatic step(input logic k);
      r_key = k;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      r_reset = 1'b1;
      step(1'b0);
      step(1'b0);
      r_reset = 1'b0;
   endtask

   initial begin
      int unsigned npulse;
      logic        exp_p;

      n_checks = 0;
      n_errors = 0;
      r_key    = 1'b0;
      r_reset  = 1'b0;

      // clean press (edges 1-12) and release (13-20)
      addv(2, 1, 0, 0, 2'd0);
      addv(4, 1, 0, 0, 2'd1);
      addv(1, 1, 1, 1, 2'd2);
      addv(5, 1, 0, 1, 2'd2);
      addv(2, 0, 0, 1, 2'd2);
      addv(4, 0, 0, 1, 2'd3);
      addv(2, 0, 0, 0, 2'd0);
      // glitch: three high cycles, no pulse
      addv(2, 1, 0, 0, 2'd0);
      addv(1, 1, 0, 0, 2'd1);
      addv(2, 0, 0, 0, 2'd1);
      addv(3, 0, 0, 0, 2'd0);
      // press bounce: high 2, low 1, high 12; then release bounce, then release
      addv(2, 1, 0, 0, 2'd0);
      addv(1, 0, 0, 0, 2'd1);
      addv(1, 1, 0, 0, 2'd1);
      addv(1, 1, 0, 0, 2'd0);
      addv(4, 1, 0, 0, 2'd1);
      addv(1, 1, 1, 1, 2'd2);
      addv(5, 1, 0, 1, 2'd2);
      addv(2, 0, 0, 1, 2'd2);
      addv(2, 1, 0, 1, 2'd3);
      addv(2, 0, 0, 1, 2'd2);
      addv(4, 0, 0, 1, 2'd3);
      addv(2, 0, 0, 0, 2'd0);

      do_reset();
      check("reset pulse", int'(kif.pulse), 0);
      check("reset key_level", int'(kif.key_level), 0);
      check("reset state", int'(kif.state), 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].key);
         check($sformatf("vec%0d pulse", i), int'(kif.pulse), int'(vecs[i].pulse));
         check($sformatf("vec%0d key_level", i), int'(kif.key_level), int'(vecs[i].lvl));
         check($sformatf("vec%0d state", i), int'(kif.state), int'(vecs[i].st));
      end

      // reset asserted while in DB_PRESS with the key still held
      do_reset();
      for (int e = 1; e <= 5; e++) step(1'b1);
      check("pre-reset state", int'(kif.state), 1);
      r_reset = 1'b1;
      step(1'b1);
      r_reset = 1'b0;
      check("mid reset pulse", int'(kif.pulse), 0);
      check("mid reset key_level", int'(kif.key_level), 0);
      check("mid reset state", int'(kif.state), 0);
      for (int e = 1; e <= 9; e++) begin
         step(1'b1);
         check($sformatf("post-reset e%0d pulse", e), int'(kif.pulse), (e == 7) ? 1 : 0);
         check($sformatf("post-reset e%0d key_level", e), int'(kif.key_level), (e >= 7) ? 1 : 0);
      end

      // zero debounce window: pulse after edge 4; main instance after edge 7
      do_reset();
      for (int e = 1; e <= 8; e++) begin
         step(1'b1);
         check($sformatf("db0 e%0d pulse", e), int'(kif0.pulse), (e == 4) ? 1 : 0);
         check($sformatf("db4 e%0d pulse", e), int'(kif.pulse), (e == 7) ? 1 : 0);
      end
      for (int e = 1; e <= 6; e++) step(1'b0);
      check("db0 release state", int'(kif0.state), 0);
      check("db0 release key_level", int'(kif0.key_level), 0);

      // long hold: repeat pulses only with the auto-repeat build
      do_reset();
      npulse = 0;
      for (int e = 1; e <= 47; e++) begin
         step(1'b1);
         exp_p = (e == 7);
`ifdef KEY_PULSE_AUTOREPEAT_EN
         if ((e >= 17) && (((e - 17) % 5) == 0)) exp_p = 1'b1;
`endif
         if (kif.pulse) npulse++;
         check($sformatf("hold e%0d pulse", e), int'(kif.pulse), int'(exp_p));
      end
`ifdef KEY_PULSE_AUTOREPEAT_EN
      check("hold pulse count", int'(npulse), 8);
`else
      check("hold pulse count", int'(npulse), 1);
`endif
      check("hold key_level", int'(kif.key_level), 1);
      for (int e = 1; e <= 8; e++) begin
         step(1'b0);
         check($sformatf("hold release e%0d pulse", e), int'(kif.pulse), 0);
      end
      check("hold release state", int'(kif.state), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
